// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: row-reduction accumulator for fp16 product streams.
// Accepts operands up to a last flag, issues one add per operand after the
// first to an external sequential fp16 adder (start/ready handshake), and
// emits the sum with an element count and sticky status flags.
// Optional feature: define ACC_TIMEOUT_EN to enable the adder timeout
// (out_err, discard of the remaining stream); otherwise out_err is tied 0.
module fp16_accum_seq #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             add_start,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_sum,
    input  logic             add_v,
    input  logic             add_u,
    input  logic             add_z,
    input  logic             add_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_v,
    output logic             out_u,
    output logic             out_z,
    output logic             out_err
);

    localparam logic [2:0] S_FIRST = 3'd0;
    localparam logic [2:0] S_NEXT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]       r_state;
    logic             r_rst_done;
    logic [15:0]      r_acc;
    logic [15:0]      r_opb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_seen_busy;
    logic             r_v;
    logic             r_u;
    logic             r_z;

    logic             w_in_fire;
    logic             w_capture;
    logic             w_discard;

`ifdef ACC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             w_timeout;

    // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle unless that cycle captures.
    assign w_timeout = (r_state == S_WAIT) && !w_capture &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_discard = r_err;
    assign out_err   = r_err;
`else
    assign w_discard = 1'b0;
    assign out_err   = 1'b0;
`endif

    assign w_in_fire = in_valid && in_ready;
    // A result is only taken once the adder has been seen busy, so a stale
    // ready left over from before the issue is never mistaken for completion.
    assign w_capture = (r_state == S_WAIT) && add_ready && r_seen_busy;

    assign in_ready  = r_rst_done && ((r_state == S_FIRST) || (r_state == S_NEXT));
    assign add_start = (r_state == S_ISSUE);
    assign add_a     = r_acc;
    assign add_b     = r_opb;
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_acc;
    assign out_count = r_cnt;
    assign out_v     = r_v;
    assign out_u     = r_u;
    assign out_z     = r_z;

    // Stream sequencing, accumulator, counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FIRST;
            r_rst_done  <= 1'b0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_seen_busy <= 1'b0;
            r_v         <= 1'b0;
            r_u         <= 1'b0;
            r_z         <= 1'b0;
`ifdef ACC_TIMEOUT_EN
            r_tmo       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_rst_done <= 1'b1;
            case (r_state)
                S_FIRST: begin
                    if (w_in_fire) begin
                        r_acc <= in_data;
                        r_cnt <= CNT_W'(1);
                        r_v   <= 1'b0;
                        r_u   <= 1'b0;
                        r_z   <= (in_data[14:0] == '0);
`ifdef ACC_TIMEOUT_EN
                        r_err <= 1'b0;
`endif
                        r_state <= in_last ? S_OUT : S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_in_fire) begin
                        if (w_discard) begin
                            if (in_last) begin
                                r_state <= S_OUT;
                            end
                        end else begin
                            r_opb  <= in_data;
                            r_last <= in_last;
                            if (r_cnt != '1) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (add_ready) begin
                        r_seen_busy <= 1'b0;
`ifdef ACC_TIMEOUT_EN
                        r_tmo       <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!add_ready) begin
                        r_seen_busy <= 1'b1;
                    end
                    if (w_capture) begin
                        r_acc   <= add_sum;
                        r_v     <= r_v | add_v;
                        r_u     <= r_u | add_u;
                        r_z     <= add_z;
                        r_state <= r_last ? S_OUT : S_NEXT;
                    end
`ifdef ACC_TIMEOUT_EN
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= r_last ? S_OUT : S_NEXT;
                    end
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_FIRST;
                    end
                end
                default: begin
                    r_state <= S_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Testbench for fp16_accum_seq: models the sequential fp16 adder with real
// arithmetic, drives operand streams, and checks results via a scoreboard.
`timescale 1ns/1ps
module tb_fp16_accum_seq;

    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             add_start;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_sum = '0;
    logic             add_v = 1'b0;
    logic             add_u = 1'b0;
    logic             add_z = 1'b0;
    logic             add_ready = 1'b1;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_v;
    logic             out_u;
    logic             out_z;
    logic             out_err;

    fp16_accum_seq #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .add_v(add_v), .add_u(add_u), .add_z(add_z), .add_ready(add_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_v(out_v), .out_u(out_u), .out_z(out_z),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0]      d;
        logic [CNT_W-1:0] c;
        logic             v, u, z, e;
    } res_t;

    typedef struct {
        logic [15:0] a, b;
        logic        v, u;
    } add_t;

    res_t exp_q[$];
    add_t add_q[$];

    int total = 0;
    int bad   = 0;

    int busy_cycles = 3;
    int rec_max     = 0;
    int rdy_pct     = 100;
    int gap_max     = 0;
    int n_issue     = 0;
    logic hold      = 1'b0;

    logic [15:0] ops[0:299];
    logic        inj_v[0:299];
    logic        inj_u[0:299];
    int          acc_cyc[0:299];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic finish_tb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic real fp16_to_real(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        e = int'(h[14:10]) - 15;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    // Exact encode; only called on values representable in fp16 normals.
    function automatic logic [15:0] real_to_fp16(input real r);
        real        a;
        int         e;
        logic       s;
        logic [9:0] m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = 10'($rtoi((a - 1.0) * 1024.0));
        return {s, 5'(e), m};
    endfunction

    function automatic logic [15:0] rnd_op(input int kmax);
        real v;
        v = real'($urandom_range(1, kmax)) * 0.5;
        if ($urandom_range(0, 1) == 1) v = -v;
        return real_to_fp16(v);
    endfunction

    // Sequential adder model: ready drops for busy_cycles after a start,
    // then the sum is presented; optional idle recovery keeps ready low.
    initial begin
        logic [15:0] s;
        add_t        t;
        logic        iv, iu;
        int          rc;
        forever begin
            @(negedge clk);
            if (rst_n && add_start && add_ready) begin
                n_issue++;
                iv = 1'b0;
                iu = 1'b0;
                if (add_q.size() > 0) begin
                    t = add_q.pop_front();
                    chk("add_a", add_a, t.a);
                    chk("add_b", add_b, t.b);
                    iv = t.v;
                    iu = t.u;
                end
                s = real_to_fp16(fp16_to_real(add_a) + fp16_to_real(add_b));
                @(posedge clk); #1 add_ready = 1'b0;
                repeat (busy_cycles - 1) @(posedge clk);
                @(posedge clk); #1;
                add_ready = 1'b1;
                add_sum   = s;
                add_v     = iv;
                add_u     = iu;
                add_z     = (s[14:0] == 15'd0);
                rc = (rec_max > 0) ? int'($urandom_range(0, rec_max)) : 0;
                if (rc > 0) begin
                    @(posedge clk); #1 add_ready = 1'b0;
                    repeat (rc - 1) @(posedge clk);
                    @(posedge clk); #1 add_ready = 1'b1;
                end
            end
        end
    end

    // Downstream acceptance.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = !hold && ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Scoreboard monitor: compares every accepted result.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_without_expect", 32'(exp_q.size()), 1);
                end else begin
                    r = exp_q.pop_front();
                    chk("out_data",  out_data,  r.d);
                    chk("out_count", out_count, r.c);
                    chk("out_v",     out_v,     r.v);
                    chk("out_u",     out_u,     r.u);
                    chk("out_z",     out_z,     r.z);
                    chk("out_err",   out_err,   r.e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        finish_tb();
    end

    task automatic drive(input logic [15:0] d, input logic l, output int c);
        int w;
        w = 0;
        c = -1;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (c < 0) begin
            @(negedge clk);
            if (in_ready) begin
                c = cyc;
            end else begin
                w++;
                if (w > 400) begin
                    total++;
                    bad++;
                    $display("FAIL in_accept_timeout: waited %0d cycles, required acceptance within 400", w);
                    finish_tb();
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: sequential real-valued sum of the stream.
    task automatic send_stream(input int n);
        real         s;
        res_t        r;
        add_t        t;
        logic [15:0] cur;
        s   = fp16_to_real(ops[0]);
        cur = ops[0];
        r.v = 1'b0;
        r.u = 1'b0;
        r.z = (ops[0][14:0] == 15'd0);
        r.e = 1'b0;
        for (int i = 1; i < n; i++) begin
            t.a = cur;
            t.b = ops[i];
            t.v = inj_v[i];
            t.u = inj_u[i];
            add_q.push_back(t);
            s   = s + fp16_to_real(ops[i]);
            cur = real_to_fp16(s);
            r.v = r.v | inj_v[i];
            r.u = r.u | inj_u[i];
            r.z = (s == 0.0);
        end
        r.d = cur;
        r.c = CNT_W'((n > SAT) ? SAT : n);
        exp_q.push_back(r);
        for (int i = 0; i < n; i++) drive(ops[i], (i == n - 1), acc_cyc[i]);
    endtask

    task automatic clear_inj();
        for (int i = 0; i < 300; i++) begin
            inj_v[i] = 1'b0;
            inj_u[i] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 3000) begin @(posedge clk); w++; end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 0);
        #1;
    endtask

    initial begin
        int          c;
        int          iss0;
        int          w;
        int          nbad;
        logic [31:0] snap;
        clear_inj();

        // Reset state and rst_done gating of in_ready.
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {out_valid, in_ready, add_start, out_data, out_count,
                           out_v, out_u, out_z, out_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_gated_after_release", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_rst_done", in_ready, 1);
        @(posedge clk); #1;

        // Single-element stream: no adder use, result one cycle after accept.
        iss0   = n_issue;
        ops[0] = 16'h3C00;
        send_stream(1);
        chk("single_out_valid_latency", out_valid, 1);
        wait_drain();
        chk("single_no_add_start", n_issue - iss0, 0);

        // 1 + 2 + 3 = 6 with nominal adder timing.
        iss0   = n_issue;
        ops[0] = 16'h3C00;
        ops[1] = 16'h4000;
        ops[2] = 16'h4200;
        send_stream(3);
        chk("accept_gap_first_second", acc_cyc[1] - acc_cyc[0], 1);
        chk("accept_gap_per_element", acc_cyc[2] - acc_cyc[1], 6);
        wait_drain();
        chk("three_elem_add_starts", n_issue - iss0, 2);

        // Cancellation to zero.
        ops[0] = 16'h4000;
        ops[1] = 16'hC000;
        send_stream(2);
        wait_drain();

        // Overflow on the second add is sticky; zero comes from final add only.
        ops[0]   = 16'h3C00;
        ops[1]   = 16'hBC00;
        ops[2]   = 16'h4000;
        ops[3]   = 16'h3C00;
        inj_v[2] = 1'b1;
        hold     = 1'b1;
        send_stream(4);
        clear_inj();
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        chk("stall_out_valid_seen", out_valid, 1);
        snap = {out_data, out_count, out_v, out_u, out_z, out_err};
        nbad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                snap !== {out_data, out_count, out_v, out_u, out_z, out_err}) nbad++;
        end
        chk("stall_outputs_stable", nbad, 0);
        @(posedge clk); #1 hold = 1'b0;
        wait_drain();

        // Reset while the adder is busy, then a fresh single stream.
        drive(16'h4000, 1'b0, c);
        drive(16'h3C00, 1'b0, c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {out_valid, in_ready, add_start, out_data, out_count,
                               out_v, out_u, out_z, out_err}, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        add_q.delete();
        ops[0] = 16'h3800;
        send_stream(1);
        wait_drain();

        // Randomized streams with backpressure, gaps and adder recovery.
        rdy_pct = 70;
        rec_max = 3;
        gap_max = 2;
        for (int s = 0; s < 30; s++) begin
            int n;
            n           = $urandom_range(1, 8);
            busy_cycles = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                ops[i]   = rnd_op(8);
                inj_v[i] = ($urandom_range(0, 7) == 0);
                inj_u[i] = ($urandom_range(0, 7) == 0);
            end
            send_stream(n);
        end
        wait_drain();
        clear_inj();

        // Element count saturation on a long stream.
        rdy_pct     = 100;
        rec_max     = 0;
        gap_max     = 0;
        busy_cycles = 3;
        for (int i = 0; i < 260; i++) ops[i] = rnd_op(4);
        send_stream(260);
        wait_drain();

`ifdef ACC_TIMEOUT_EN
        // Adder stalls past the timeout: error flagged, rest of stream dropped.
        begin
            res_t r;
            add_t t;
            busy_cycles = 20;
            t.a = 16'h3C00; t.b = 16'h4000; t.v = 1'b0; t.u = 1'b0;
            add_q.push_back(t);
            r.d = 16'h3C00; r.c = CNT_W'(2); r.v = 1'b0; r.u = 1'b0; r.z = 1'b0; r.e = 1'b1;
            exp_q.push_back(r);
            drive(16'h3C00, 1'b0, c);
            drive(16'h4000, 1'b0, c);
            drive(16'h4200, 1'b1, c);
            wait_drain();
            repeat (30) begin @(posedge clk); #1; end
            busy_cycles = 3;
        end
`endif

        finish_tb();
    end

endmodule
